game_ctrl: RTL and testbench
============================

GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 11: points needed to win a game; the legal range is 1..15.
REQ-002 Parameter FREEZE_FRAMES, default 60: number of frame_tick pulses the ball is frozen after a point; the legal range is 1..255.
REQ-003 clk  input  1  system clock; all logic is on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-006 serve  input  1  serve button level, already synchronised to clk.
REQ-007 miss_l  input  1  one-cycle pulse: ball passed the left paddle.
REQ-008 miss_r  input  1  one-cycle pulse: ball passed the right paddle.
REQ-009 ball_run  output  1  ball motion enable.
REQ-010 ball_reset  output  1  holds the ball at the serve position.
REQ-011 serve_side  output  1  serving player: 0 = left, 1 = right.
REQ-012 score_l, score_r  output  4 each  player scores, unsigned.
REQ-013 game_over  output  1  a game has been won.
REQ-014 winner  output  1  winning player (0 = left, 1 = right); valid only while game_over = 1.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, PLAY, POINT, CHECK, OVER.
REQ-016 Serve press SHALL mean a rising edge of serve (0 in the previous cycle, 1 now); a held level SHALL NOT re-trigger.
REQ-017 IDLE: ball_run=0 and ball_reset=1; a serve press SHALL move to PLAY on the next edge.
REQ-018 PLAY: ball_run=1 and ball_reset=0, both registered, so they take effect 1 cycle after entering PLAY.
REQ-019 PLAY with miss_l only: score_r SHALL increment, serve_side SHALL become 0, and the FSM SHALL go to POINT.
REQ-020 PLAY with miss_r only: score_l SHALL increment, serve_side SHALL become 1, and the FSM SHALL go to POINT.
REQ-021 PLAY with miss_l and miss_r in the same cycle: no score change, serve_side unchanged, and the FSM SHALL go to POINT (replay).
REQ-022 miss_l and miss_r SHALL be ignored in every state except PLAY.
REQ-023 POINT: ball_run=0 and ball_reset=1; an 8-bit freeze counter SHALL clear on entry and count frame_tick pulses.
REQ-024 POINT SHALL go to CHECK in the cycle after the counter reaches FREEZE_FRAMES.
REQ-025 Serve presses during POINT SHALL be ignored.
REQ-026 CHECK SHALL last exactly 1 cycle: go to OVER if a win condition holds, otherwise go to IDLE.
REQ-027 Win condition, baseline: the player whose score is >= WIN_SCORE wins.
REQ-028 OVER: game_over=1, winner is held, ball_run=0 and ball_reset=1.
REQ-029 A serve press in OVER SHALL zero both scores, clear game_over, keep serve_side, and go to IDLE.
REQ-030 Scores SHALL saturate at 15 and never wrap.

Reset
REQ-031 While rst=1 the block SHALL be forced as follows, with rst taking priority over every input including a serve edge and a miss pulse: state=IDLE, scores=0, serve_side=0, game_over=0, winner=0, ball_run=0, ball_reset=1, freeze counter=0, edge-detect history=0.
REQ-032 Reset asserted in any state, including mid-POINT, SHALL give the REQ-031 values one cycle later.

Configuration
REQ-033 The macro GAME_CTRL_WIN_BY_TWO_EN SHALL select the win rule, as follows.
REQ-034 With the macro defined, a player SHALL win when their score is >= WIN_SCORE and leads the other score by at least 2, or when their score reaches 15.
REQ-035 Without the macro, the REQ-027 rule SHALL apply unchanged.

Structure
REQ-036 Package game_pkg SHALL hold the state enum typedef, the SCORE_W=4 constant and the side encodings (LEFT=0, RIGHT=1).
REQ-037 The serve rising-edge detector SHALL be a separate sub-module, edge_detect, instantiated once.

Verification
REQ-038 Reset then a serve press: ball_run=1 exactly 2 cycles after the serve edge; scores stay 0/0.
REQ-039 PLAY, miss_r pulse: score_l=1, serve_side=1; ball_reset=1 for 60 frame_ticks, then IDLE; a serve held at 1 throughout does not re-serve.
REQ-040 PLAY, miss_l and miss_r in the same cycle: scores unchanged and POINT is entered.
REQ-041 WIN_SCORE=3, three miss_r points: game_over=1, winner=0; the next serve press clears the scores to 0/0.
REQ-042 With GAME_CTRL_WIN_BY_TWO_EN, WIN_SCORE=3, scores at 3/3 then 4/3: game_over stays 0 at both; at 5/3, game_over=1 and winner=0.
REQ-043 rst pulsed 10 frame_ticks into POINT: all outputs take the reset values the next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game controller.
package game_pkg;

  localparam int unsigned SCORE_W = 4;
  localparam int unsigned FRZ_W   = 8;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  localparam logic LEFT  = 1'b0;
  localparam logic RIGHT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    POINT,
    CHECK,
    OVER
  } state_t;

  // Score increment that sticks at the top of the range instead of wrapping.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for an already-synchronised level input.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise_c
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= sig;
  end

  assign rise_c = sig & ~prev;

endmodule

// File: rtl/game_ctrl.sv
// Pong-style game sequencer: serve, scoring, post-point freeze, win detection.
// GAME_CTRL_WIN_BY_TWO_EN selects the win-by-two rule (default: first to WIN_SCORE).
module game_ctrl
  import game_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = 11,
  parameter int unsigned FREEZE_FRAMES = 60
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               serve,
  input  logic               miss_l,
  input  logic               miss_r,
  output logic               ball_run,
  output logic               ball_reset,
  output logic               serve_side,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               game_over,
  output logic               winner
);

  localparam logic [SCORE_W-1:0] WIN_S = SCORE_W'(WIN_SCORE);
  localparam logic [FRZ_W-1:0]   FRZ   = FRZ_W'(FREEZE_FRAMES);

  state_t             state, next_state;
  logic [FRZ_W-1:0]   frz_cnt, frz_nx;
  logic [SCORE_W-1:0] score_l_nx, score_r_nx;
  logic               side_nx, over_nx, winner_nx, run_nx, brst_nx;
  logic               press_c, win_l_c, win_r_c;

  edge_detect u_serve_edge (
    .clk    (clk),
    .rst    (rst),
    .sig    (serve),
    .rise_c (press_c)
  );

`ifdef GAME_CTRL_WIN_BY_TWO_EN
  // 5-bit compare so other+2 cannot wrap at the top of the score range.
  assign win_l_c = (score_l == SCORE_MAX) ||
                   ((score_l >= WIN_S) && ({1'b0, score_l} >= {1'b0, score_r} + 5'd2));
  assign win_r_c = (score_r == SCORE_MAX) ||
                   ((score_r >= WIN_S) && ({1'b0, score_r} >= {1'b0, score_l} + 5'd2));
`else
  assign win_l_c = (score_l >= WIN_S);
  assign win_r_c = (score_r >= WIN_S);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      score_l    <= '0;
      score_r    <= '0;
      serve_side <= LEFT;
      game_over  <= 1'b0;
      winner     <= LEFT;
      ball_run   <= 1'b0;
      ball_reset <= 1'b1;
      frz_cnt    <= '0;
    end else begin
      state      <= next_state;
      score_l    <= score_l_nx;
      score_r    <= score_r_nx;
      serve_side <= side_nx;
      game_over  <= over_nx;
      winner     <= winner_nx;
      ball_run   <= run_nx;
      ball_reset <= brst_nx;
      frz_cnt    <= frz_nx;
    end
  end

  always_comb begin
    next_state = state;
    score_l_nx = score_l;
    score_r_nx = score_r;
    side_nx    = serve_side;
    over_nx    = game_over;
    winner_nx  = winner;
    frz_nx     = frz_cnt;
    // Ball controls follow the current state, so they lag it by one cycle.
    run_nx     = (state == PLAY);
    brst_nx    = (state != PLAY);

    case (state)
      IDLE: begin
        if (press_c) next_state = PLAY;
      end
      PLAY: begin
        if (miss_l || miss_r) begin
          next_state = POINT;
          frz_nx     = '0;
          if (miss_l && !miss_r) begin
            score_r_nx = sat_inc(score_r);
            side_nx    = LEFT;
          end else if (miss_r && !miss_l) begin
            score_l_nx = sat_inc(score_l);
            side_nx    = RIGHT;
          end
        end
      end
      POINT: begin
        if (frz_cnt == FRZ)  next_state = CHECK;
        else if (frame_tick) frz_nx     = frz_cnt + FRZ_W'(1);
      end
      CHECK: begin
        if (win_l_c || win_r_c) begin
          next_state = OVER;
          over_nx    = 1'b1;
          winner_nx  = win_r_c ? RIGHT : LEFT;
        end else begin
          next_state = IDLE;
        end
      end
      OVER: begin
        if (press_c) begin
          next_state = IDLE;
          score_l_nx = '0;
          score_r_nx = '0;
          over_nx    = 1'b0;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios plus randomized play against a reference model.
module tb_game_ctrl;

  localparam int unsigned TB_WIN = 3;
  localparam int unsigned TB_FRZ = 60;

  localparam int PH_IDLE  = 0;
  localparam int PH_PLAY  = 1;
  localparam int PH_POINT = 2;
  localparam int PH_CHECK = 3;
  localparam int PH_OVER  = 4;

  logic       clk = 1'b0;
  logic       rst, frame_tick, serve, miss_l, miss_r;
  logic       ball_run, ball_reset, serve_side, game_over, winner;
  logic [3:0] score_l, score_r;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_ctrl #(.WIN_SCORE(TB_WIN), .FREEZE_FRAMES(TB_FRZ)) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .serve      (serve),
    .miss_l     (miss_l),
    .miss_r     (miss_r),
    .ball_run   (ball_run),
    .ball_reset (ball_reset),
    .serve_side (serve_side),
    .score_l    (score_l),
    .score_r    (score_r),
    .game_over  (game_over),
    .winner     (winner)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game rules in plain integers, updated once per clock.
  int m_phase, m_l, m_r, m_ticks;
  bit m_side, m_over, m_winner, m_run, m_brst, m_prev;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    bit press, wl, wr;
    int ph;
    if (rst) begin
      m_phase = PH_IDLE; m_l = 0; m_r = 0; m_ticks = 0;
      m_side = 0; m_over = 0; m_winner = 0; m_run = 0; m_brst = 1; m_prev = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      press  = serve && !m_prev;
      m_prev = serve;
      ph     = m_phase;
      m_run  = (ph == PH_PLAY);
      m_brst = (ph != PH_PLAY);
`ifdef GAME_CTRL_WIN_BY_TWO_EN
      wl = (m_l >= TB_WIN && m_l - m_r >= 2) || m_l >= 15;
      wr = (m_r >= TB_WIN && m_r - m_l >= 2) || m_r >= 15;
`else
      wl = m_l >= TB_WIN;
      wr = m_r >= TB_WIN;
`endif
      if (ph == PH_IDLE && press) m_phase = PH_PLAY;
      else if (ph == PH_PLAY && (miss_l || miss_r)) begin
        m_phase = PH_POINT;
        m_ticks = 0;
        if (miss_l && !miss_r) begin m_r = (m_r < 15) ? m_r + 1 : 15; m_side = 0; end
        if (miss_r && !miss_l) begin m_l = (m_l < 15) ? m_l + 1 : 15; m_side = 1; end
      end else if (ph == PH_POINT) begin
        if (m_ticks == TB_FRZ) m_phase = PH_CHECK;
        else if (frame_tick)   m_ticks++;
      end else if (ph == PH_CHECK) begin
        if (wl || wr) begin m_phase = PH_OVER; m_over = 1; m_winner = wr; end
        else m_phase = PH_IDLE;
      end else if (ph == PH_OVER && press) begin
        m_phase = PH_IDLE; m_l = 0; m_r = 0; m_over = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ball_run",   32'(ball_run),   32'(m_run));
      chk("ball_reset", 32'(ball_reset), 32'(m_brst));
      chk("serve_side", 32'(serve_side), 32'(m_side));
      chk("score_l",    32'(score_l),    32'(m_l));
      chk("score_r",    32'(score_r),    32'(m_r));
      chk("game_over",  32'(game_over),  32'(m_over));
      if (m_over) chk("winner", 32'(winner), 32'(m_winner));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play_point(input bit lm, input bit rm);
    serve = 1'b0; step(1);
    serve = 1'b1; step(3);
    miss_l = lm; miss_r = rm; step(1);
    miss_l = 1'b0; miss_r = 1'b0;
    frame_tick = 1'b1; step(TB_FRZ);
    frame_tick = 1'b0; step(3);
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0; serve = 1'b0; miss_l = 1'b0; miss_r = 1'b0;
    step(3);
    chk("rst_score_l", 32'(score_l), 0);
    chk("rst_score_r", 32'(score_r), 0);
    chk("rst_ball_reset", 32'(ball_reset), 1);
    chk("rst_ball_run", 32'(ball_run), 0);
    chk("rst_game_over", 32'(game_over), 0);
    rst = 1'b0; step(2);

    // Serve: ball_run rises two cycles after the press is sampled.
    serve = 1'b1; step(1);
    chk("serve_run_1cyc", 32'(ball_run), 0);
    step(1);
    chk("serve_run_2cyc", 32'(ball_run), 1);
    chk("serve_scores", 32'({score_l, score_r}), 0);

    // miss_r scores for left, freeze, then idle with serve still held.
    miss_r = 1'b1; step(1); miss_r = 1'b0;
    chk("missr_score_l", 32'(score_l), 1);
    chk("missr_side", 32'(serve_side), 1);
    frame_tick = 1'b1; step(1);
    chk("missr_frozen", 32'(ball_reset), 1);
    step(TB_FRZ - 1); frame_tick = 1'b0; step(4);
    chk("held_no_reserve", 32'(ball_run), 0);
    chk("held_ball_reset", 32'(ball_reset), 1);

    // Simultaneous misses: replay with no score change.
    serve = 1'b0; step(1); serve = 1'b1; step(3);
    miss_l = 1'b1; miss_r = 1'b1; step(1); miss_l = 1'b0; miss_r = 1'b0;
    chk("both_score_l", 32'(score_l), 1);
    chk("both_score_r", 32'(score_r), 0);
    chk("both_side", 32'(serve_side), 1);
    frame_tick = 1'b1; step(1);
    chk("both_point_run", 32'(ball_run), 0);
    chk("both_point_reset", 32'(ball_reset), 1);
    step(TB_FRZ - 1); frame_tick = 1'b0; step(3);

    // Left reaches 3/0 and wins; serve press clears.
    play_point(1'b0, 1'b1);
    chk("two_zero_over", 32'(game_over), 0);
    play_point(1'b0, 1'b1);
    chk("win_score_l", 32'(score_l), 3);
    chk("win_game_over", 32'(game_over), 1);
    chk("win_winner", 32'(winner), 0);
    serve = 1'b0; step(1); serve = 1'b1; step(1);
    chk("clr_scores", 32'({score_l, score_r}), 0);
    chk("clr_game_over", 32'(game_over), 0);
    chk("clr_side_kept", 32'(serve_side), 1);

`ifdef GAME_CTRL_WIN_BY_TWO_EN
    play_point(1'b0, 1'b1); play_point(1'b1, 1'b0);
    play_point(1'b0, 1'b1); play_point(1'b1, 1'b0);
    play_point(1'b0, 1'b1); play_point(1'b1, 1'b0);
    chk("wb2_3_3_scores", 32'({score_l, score_r}), 32'h33);
    chk("wb2_3_3_over", 32'(game_over), 0);
    play_point(1'b0, 1'b1);
    chk("wb2_4_3_over", 32'(game_over), 0);
    play_point(1'b0, 1'b1);
    chk("wb2_5_3_score", 32'(score_l), 5);
    chk("wb2_5_3_over", 32'(game_over), 1);
    chk("wb2_5_3_winner", 32'(winner), 0);
    serve = 1'b0; step(1); serve = 1'b1; step(1);
`endif

    // Reset 10 frame_ticks into a freeze, with a miss pulse competing.
    serve = 1'b0; step(1); serve = 1'b1; step(3);
    miss_l = 1'b1; step(1); miss_l = 1'b0;
    chk("pre_rst_score_r", 32'(score_r), 1);
    frame_tick = 1'b1; step(10);
    rst = 1'b1; miss_l = 1'b1; step(1);
    chk("midpt_rst_scores", 32'({score_l, score_r}), 0);
    chk("midpt_rst_side", 32'(serve_side), 0);
    chk("midpt_rst_run", 32'(ball_run), 0);
    chk("midpt_rst_breset", 32'(ball_reset), 1);
    chk("midpt_rst_over", 32'(game_over), 0);
    chk("midpt_rst_winner", 32'(winner), 0);
    rst = 1'b0; miss_l = 1'b0; frame_tick = 1'b0; serve = 1'b0; step(2);

    // Randomized play; the per-cycle compare checks against the model.
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 9) == 0) serve = ~serve;
      miss_l     = ($urandom_range(0, 39) == 0);
      miss_r     = ($urandom_range(0, 39) == 0);
      frame_tick = ($urandom_range(0, 1) == 1);
      rst        = ($urandom_range(0, 999) == 0);
      step(1);
    end
    rst = 1'b0; miss_l = 1'b0; miss_r = 1'b0; frame_tick = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
